// File: rtl/uart_tx_piso_if.sv
// UART transmit framer bus: baud enable, send handshake,
// frame options and serial line status.
interface uart_tx_piso_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  i_BaudTick;
  logic                  i_Send;
  logic [DATA_WIDTH-1:0] i_DataIn;
  logic [1:0]            i_ParityType;
  logic                  i_StopBits;
  logic                  o_DataTx;
  logic                  o_Ready;
  logic                  o_Busy;
  logic                  o_Done;

  modport master (
    output i_BaudTick,
    output i_Send,
    output i_DataIn,
    output i_ParityType,
    output i_StopBits,
    input  o_DataTx,
    input  o_Ready,
    input  o_Busy,
    input  o_Done
  );

  modport slave (
    input  i_BaudTick,
    input  i_Send,
    input  i_DataIn,
    input  i_ParityType,
    input  i_StopBits,
    output o_DataTx,
    output o_Ready,
    output o_Busy,
    output o_Done
  );
endinterface

// File: rtl/uart_tx_piso.sv
// UART transmit framer / PISO shifter: start, LSB-first data,
// optional parity, 1 or 2 stop bits, one bit per baud tick.
module uart_tx_piso #(
  parameter int DATA_WIDTH = 8
) (
  input logic          i_Clk,
  input logic          i_ResetN,
  uart_tx_piso_if.slave bus
);
  localparam int CW = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t                r_State;
  logic [DATA_WIDTH-1:0] r_Shift;
  logic [CW-1:0]         r_BitCnt;
  logic                  r_StopCnt;
  logic                  r_Stop2;
  logic                  r_ParEn;
  logic                  r_ParBit;
  logic                  r_DataTx;
  logic                  r_Ready;
  logic                  r_Busy;
  logic                  r_Done;

  always_ff @(posedge i_Clk or negedge i_ResetN) begin
    if (!i_ResetN) begin
      r_State   <= S_IDLE;
      r_Shift   <= '0;
      r_BitCnt  <= '0;
      r_StopCnt <= 1'b0;
      r_Stop2   <= 1'b0;
      r_ParEn   <= 1'b0;
      r_ParBit  <= 1'b0;
      r_DataTx  <= 1'b1;
      r_Ready   <= 1'b1;
      r_Busy    <= 1'b0;
      r_Done    <= 1'b0;
    end else begin
      r_Done <= 1'b0;
      unique case (r_State)
        S_IDLE: begin
          if (bus.i_Send) begin
            r_Shift  <= bus.i_DataIn;
            r_Stop2  <= bus.i_StopBits;
            r_ParEn  <= ^bus.i_ParityType;
            // type 10 = even -> ^data; 01 = odd -> ~^data
            r_ParBit <= bus.i_ParityType[1] ?
                        ^bus.i_DataIn : ~^bus.i_DataIn;
            r_State  <= S_ARM;
            r_Ready  <= 1'b0;
            r_Busy   <= 1'b1;
          end
        end
        S_ARM: begin
          if (bus.i_BaudTick) begin
            r_State  <= S_START;
            r_DataTx <= 1'b0;
          end
        end
        S_START: begin
          if (bus.i_BaudTick) begin
            r_State  <= S_DATA;
            r_DataTx <= r_Shift[0];
            r_Shift  <= r_Shift >> 1;
            r_BitCnt <= '0;
          end
        end
        S_DATA: begin
          if (bus.i_BaudTick) begin
            if (r_BitCnt == CW'(DATA_WIDTH - 1)) begin
              r_StopCnt <= 1'b0;
              if (r_ParEn) begin
                r_State  <= S_PAR;
                r_DataTx <= r_ParBit;
              end else begin
                r_State  <= S_STOP;
                r_DataTx <= 1'b1;
              end
            end else begin
              r_DataTx <= r_Shift[0];
              r_Shift  <= r_Shift >> 1;
              r_BitCnt <= r_BitCnt + CW'(1);
            end
          end
        end
        S_PAR: begin
          if (bus.i_BaudTick) begin
            r_State  <= S_STOP;
            r_DataTx <= 1'b1;
          end
        end
        S_STOP: begin
          if (bus.i_BaudTick) begin
            if (r_StopCnt == r_Stop2) begin
              r_State <= S_IDLE;
              r_Done  <= 1'b1;
              r_Ready <= 1'b1;
              r_Busy  <= 1'b0;
            end else begin
              r_StopCnt <= 1'b1;
            end
          end
        end
        default: begin
          r_State  <= S_IDLE;
          r_DataTx <= 1'b1;
          r_Ready  <= 1'b1;
          r_Busy   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_DataTx = r_DataTx;
  assign bus.o_Ready  = r_Ready;
  assign bus.o_Busy   = r_Busy;
  assign bus.o_Done   = r_Done;
endmodule

// File: tb/tb_uart_tx_piso.sv
// Bench for uart_tx_piso: directed frame table, corner sequences
// and random frames against a bit-list frame model.
module tb_uart_tx_piso;
  localparam int W   = 8;
  localparam int DIV = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   done_cnt = 0;
  int   tcnt = 0;
  int   bad_cnt = 0;
  logic cap_q[$];
  logic exp_q[$];

  uart_tx_piso_if #(.DATA_WIDTH(W)) bus();

  uart_tx_piso #(.DATA_WIDTH(W)) dut (
    .i_Clk   (clk),
    .i_ResetN(rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    bus.i_BaudTick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tcnt = (tcnt + 1) % DIV;
      bus.i_BaudTick = (tcnt == 0);
    end
  end

  always @(negedge clk) if (bus.o_Done) done_cnt <= done_cnt + 1;

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, got, exp);
    end
  endtask

  // frame as a plain bit list built from the framing rules
  task automatic build(input logic [W-1:0] d, input logic [1:0] pt,
                       input logic sb);
    int ones;
    exp_q = {};
    exp_q.push_back(1'b0);
    ones = 0;
    for (int i = 0; i < W; i++) begin
      exp_q.push_back(d[i]);
      if (d[i]) ones++;
    end
    if (pt == 2'b01) exp_q.push_back((ones % 2) == 0);
    if (pt == 2'b10) exp_q.push_back((ones % 2) == 1);
    exp_q.push_back(1'b1);
    if (sb) exp_q.push_back(1'b1);
  endtask

  task automatic wait_tick(input logic last, input bit en);
    for (int c = 0; c < 16 * DIV; c++) begin
      @(negedge clk);
      if (en && (bus.o_DataTx !== last || bus.o_Busy !== 1'b1 ||
                 bus.o_Done !== 1'b0)) bad_cnt++;
      @(posedge clk);
      if (bus.i_BaudTick) return;
    end
    bad_cnt++;
    $display("FAIL tick_wait: got no tick required tick");
  endtask

  task automatic accept(input logic [W-1:0] d, input logic [1:0] pt,
                        input logic sb);
    bus.i_DataIn = d;
    bus.i_ParityType = pt;
    bus.i_StopBits = sb;
    bus.i_Send = 1'b1;
    @(posedge clk);
    #1;
    bus.i_Send = 1'b0;
    bus.i_DataIn = W'($urandom);
    bus.i_ParityType = 2'($urandom);
    bus.i_StopBits = 1'($urandom);
    chk("accept_busy", 32'({bus.o_Ready, bus.o_Busy}), 32'b01);
  endtask

  task automatic capture(input int inj_at);
    logic last;
    bit   got_done;
    cap_q = {};
    last = 1'b1;
    got_done = 0;
    bad_cnt = 0;
    for (int k = 0; k < 20 && !got_done; k++) begin
      wait_tick(last, 1);
      #1;
      if (bus.o_Done) got_done = 1;
      else begin
        cap_q.push_back(bus.o_DataTx);
        last = bus.o_DataTx;
        if (k == inj_at) begin
          bus.i_Send = 1'b1;
          bus.i_DataIn = '1;
          @(posedge clk);
          #1;
          bus.i_Send = 1'b0;
        end
      end
    end
    chk("done_seen", 32'(got_done), 32'd1);
    chk("line_stable", 32'(bad_cnt), 32'd0);
  endtask

  task automatic cmp_frame(input string nm);
    logic [31:0] gv;
    logic [31:0] ev;
    gv = '0;
    ev = '0;
    foreach (cap_q[i]) if (i < 32) gv[i] = cap_q[i];
    foreach (exp_q[i]) if (i < 32) ev[i] = exp_q[i];
    chk({nm, "_len"}, 32'(cap_q.size()), 32'(exp_q.size()));
    chk({nm, "_bits"}, gv, ev);
  endtask

  task automatic post_idle();
    chk("end_status",
        32'({bus.o_Ready, bus.o_Busy, bus.o_DataTx, bus.o_Done}),
        32'b1011);
    @(posedge clk);
    #1;
    chk("done_pulse_1clk", 32'(bus.o_Done), 32'd0);
  endtask

  task automatic run_frame(input logic [W-1:0] d, input logic [1:0] pt,
                           input logic sb, input int inj_at);
    accept(d, pt, sb);
    capture(inj_at);
    build(d, pt, sb);
    cmp_frame("frame");
    post_idle();
  endtask

  typedef struct {
    logic [W-1:0] d;
    logic [1:0]   pt;
    logic         sb;
    int           len;
    logic         par;
  } vec_t;

  vec_t tv[5];

  initial begin
    int d0;
    logic [31:0] v;
    tv[0] = '{8'hA5, 2'b00, 1'b0, 10, 1'b0};
    tv[1] = '{8'hA5, 2'b10, 1'b0, 11, 1'b0};
    tv[2] = '{8'hA5, 2'b01, 1'b0, 11, 1'b1};
    tv[3] = '{8'hA5, 2'b11, 1'b0, 10, 1'b0};
    tv[4] = '{8'h00, 2'b00, 1'b1, 11, 1'b0};

    bus.i_Send = 1'b0;
    bus.i_DataIn = '0;
    bus.i_ParityType = 2'b00;
    bus.i_StopBits = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_out",
        32'({bus.o_DataTx, bus.o_Ready, bus.o_Busy, bus.o_Done}),
        32'b1100);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++) begin
      repeat (i) @(posedge clk);
      #1;
      accept(tv[i].d, tv[i].pt, tv[i].sb);
      capture(-1);
      build(tv[i].d, tv[i].pt, tv[i].sb);
      cmp_frame("table");
      chk("table_len_abs", 32'(cap_q.size()), 32'(tv[i].len));
      if ((tv[i].pt == 2'b01 || tv[i].pt == 2'b10) && cap_q.size() > 9)
        chk("table_parity", 32'(cap_q[9]), 32'(tv[i].par));
      if (i == 0) begin
        v = '0;
        foreach (cap_q[j]) if (j < 32) v[j] = cap_q[j];
        chk("a5_8n1_bits", v, 32'h34A);
      end
      post_idle();
    end

    // Send pulsed mid-frame must not disturb or queue anything
    d0 = done_cnt;
    run_frame(8'h3C, 2'b00, 1'b0, 3);
    bad_cnt = 0;
    repeat (16 * DIV) begin
      @(negedge clk);
      if (bus.o_DataTx !== 1'b1 || bus.o_Busy !== 1'b0) bad_cnt++;
    end
    chk("no_second_frame", 32'(bad_cnt), 32'd0);
    chk("inj_done_count", 32'(done_cnt - d0), 32'd1);

    // Send held from the Done cycle: back-to-back frames
    @(posedge clk);
    #1;
    d0 = done_cnt;
    bus.i_DataIn = 8'h5A;
    bus.i_ParityType = 2'b10;
    bus.i_StopBits = 1'b0;
    bus.i_Send = 1'b1;
    @(posedge clk);
    #1;
    capture(-1);
    build(8'h5A, 2'b10, 1'b0);
    cmp_frame("b2b_first");
    chk("b2b_ready_in_done", 32'(bus.o_Ready), 32'd1);
    bus.i_DataIn = 8'hC3;
    bus.i_ParityType = 2'b00;
    bus.i_StopBits = 1'b1;
    @(posedge clk);
    #1;
    bus.i_Send = 1'b0;
    chk("b2b_accept", 32'(bus.o_Busy), 32'd1);
    capture(-1);
    build(8'hC3, 2'b00, 1'b1);
    cmp_frame("b2b_second");
    post_idle();
    chk("b2b_done_count", 32'(done_cnt - d0), 32'd2);

    // reset while data bit 4 is on the line
    d0 = done_cnt;
    accept(8'h00, 2'b00, 1'b0);
    for (int k = 0; k < 6; k++) wait_tick(1'b1, 0);
    @(negedge clk);
    chk("pre_reset_bit4", 32'(bus.o_DataTx), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset",
        32'({bus.o_DataTx, bus.o_Ready, bus.o_Busy}), 32'b110);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8 * DIV) @(posedge clk);
    #1;
    chk("reset_no_done", 32'(done_cnt - d0), 32'd0);
    run_frame(8'h96, 2'b01, 1'b1, -1);

    for (int r = 0; r < 16; r++) begin
      logic [W-1:0] rd;
      logic [1:0]   rp;
      logic         rs;
      rd = W'($urandom);
      rp = 2'($urandom);
      rs = 1'($urandom);
      repeat ($urandom_range(0, 6)) @(posedge clk);
      #1;
      run_frame(rd, rp, rs, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
